// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers shared by the subkey sequencer and PC2 permutation.
package des_pkg;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] subkey_t;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUNDS   = 16;

  // Table entries are DES bit numbers, 1 = MSB of the source vector.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic half_key_t rotl28(input half_key_t h, input logic [1:0] n);
    return (n == 2'd2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic half_key_t rotr28(input half_key_t h, input logic [1:0] n);
    return (n == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: selects the 48 subkey bits out of the 56-bit {C,D} pair.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd_i,
  output subkey_t         subkey_o
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey_o[6'(47 - i)] = cd_i[6'(56 - PC2[i])];
  end

  // DES bits 9,18,22,25,35,38,43,54 are dropped by PC2.
  logic unused_cd;
  assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                       cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_subkey_sequencer.sv
// Iterative DES key schedule: streams K1..K16 (encrypt) or K16..K1 (decrypt) over valid/ready.
module des_subkey_sequencer
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              decrypt,
  input  logic              abort,
  output logic              sk_valid,
  input  logic              sk_ready,
  output subkey_t           subkey,
  output logic [3:0]        sk_round,
  output logic              sk_last
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e     state_q, state_d;
  half_key_t  c_q, c_d, d_q, d_d;
  logic       mode_q, mode_d;
  logic [3:0] round_q, round_d;
  logic       sk_valid_q, sk_valid_d;
  logic       sk_last_q, sk_last_d;
  subkey_t    subkey_q, subkey_d;
  subkey_t    pc2_out;
  logic [CD_W-1:0] pc1_out;
  logic [1:0] shamt;
  logic       load_sk;
  logic       beat_acc;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_out[6'(55 - i)] = key_in[6'(64 - PC1[i])];
  end

  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Shift for the beat after round_q: encrypt uses SHIFT[r+1], decrypt walks the table backwards.
  assign shamt    = mode_q ? SHIFT[~round_q] : SHIFT[4'(round_q + 4'd1)];
  assign beat_acc = sk_valid_q && sk_ready;

  des_pc2 u_pc2 (
    .cd_i     ({c_d, d_d}),
    .subkey_o (pc2_out)
  );

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    d_d        = d_q;
    mode_d     = mode_q;
    round_d    = round_q;
    sk_valid_d = sk_valid_q;
    sk_last_d  = sk_last_q;
    load_sk    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d    = RUN;
          mode_d     = decrypt;
          c_d        = decrypt ? pc1_out[55:28] : rotl28(pc1_out[55:28], SHIFT[0]);
          d_d        = decrypt ? pc1_out[27:0]  : rotl28(pc1_out[27:0],  SHIFT[0]);
          round_d    = 4'd0;
          sk_valid_d = 1'b1;
          sk_last_d  = 1'b0;
          load_sk    = 1'b1;
        end
      end
      RUN: begin
        if (abort || (beat_acc && (round_q == 4'd15))) begin
          state_d    = IDLE;
          round_d    = 4'd0;
          sk_valid_d = 1'b0;
          sk_last_d  = 1'b0;
        end else if (beat_acc) begin
          c_d       = mode_q ? rotr28(c_q, shamt) : rotl28(c_q, shamt);
          d_d       = mode_q ? rotr28(d_q, shamt) : rotl28(d_q, shamt);
          round_d   = 4'(round_q + 4'd1);
          sk_last_d = (round_q == 4'd14);
          load_sk   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign subkey_d = load_sk ? pc2_out : subkey_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_q        <= '0;
      d_q        <= '0;
      mode_q     <= 1'b0;
      round_q    <= 4'd0;
      sk_valid_q <= 1'b0;
      sk_last_q  <= 1'b0;
      subkey_q   <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      d_q        <= d_d;
      mode_q     <= mode_d;
      round_q    <= round_d;
      sk_valid_q <= sk_valid_d;
      sk_last_q  <= sk_last_d;
      subkey_q   <= subkey_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign sk_valid  = sk_valid_q;
  assign subkey    = subkey_q;
  assign sk_round  = round_q;
  assign sk_last   = sk_last_q;

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// Scoreboard bench for des_subkey_sequencer: reference key schedule built from cumulative rotations.
module tb_des_subkey_sequencer;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KEY_C = 64'hA1B2C3D4E5F60718;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        decrypt;
  logic        abort;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  sk_round;
  logic        sk_last;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [47:0] obs [16];
  int          hs_cnt   = 0;
  int          hs_first = 0;
  int          hs_last  = 0;
  int          cyc      = 0;
  logic        chk_idle = 1'b0;
  logic        stall_q  = 1'b0;
  logic [47:0] held_sk;
  logic [3:0]  held_rnd;
  logic        held_last;

  des_subkey_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .abort     (abort),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .subkey    (subkey),
    .sk_round  (sk_round),
    .sk_last   (sk_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, want, $time);
    end
  endtask

  // Kn from the textbook form: PC1, rotate by the running shift total, PC2.
  function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k;
    int total;
    total = 0;
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = key[6'(64 - PC1_T[i])];
      d[5'(27 - i)] = key[6'(64 - PC1_T[i + 28])];
    end
    for (int j = 0; j < n; j++) total += SHIFT_T[j];
    for (int j = 0; j < total; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return k;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_idle) begin
      check("ready_after_last", 64'(key_ready), 64'(1));
      check("valid_after_last", 64'(sk_valid), 64'(0));
      chk_idle = 1'b0;
    end
    if (stall_q && sk_valid) begin
      check("stall_subkey", 64'(subkey), 64'(held_sk));
      check("stall_round", 64'(sk_round), 64'(held_rnd));
      check("stall_last", 64'(sk_last), 64'(held_last));
    end
    stall_q   = rst_n && sk_valid && !sk_ready;
    held_sk   = subkey;
    held_rnd  = sk_round;
    held_last = sk_last;
    if (rst_n && sk_valid && sk_ready) begin
      hs_cnt++;
      obs[sk_round] = subkey;
      if (sk_round == 4'd0) hs_first = cyc;
      if (sk_last) begin
        hs_last  = cyc;
        chk_idle = 1'b1;
      end
      if (sb.size() == 0) begin
        check("spurious_beat", 64'(sk_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("subkey", 64'(subkey), 64'(e.sk));
        check("sk_round", 64'(sk_round), 64'(e.rnd));
        check("sk_last", 64'(sk_last), 64'(e.last));
      end
    end
  end

  task automatic send_key(input logic [63:0] k, input logic dec);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_in    = k;
    decrypt   = dec;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = key_ready;
    end
    if (!ok) check("key_accept", 64'(key_ready), 64'(1));
    for (int r = 0; r < 16; r++) sb.push_back('{ref_key(k, dec ? 16 - r : r + 1), 4'(r), r == 15});
    hs_cnt = 0;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) sk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = (sb.size() == 0) && key_ready;
    end
    if (!done) check("schedule_done", 64'(key_ready), 64'(1));
    check("sb_drained", 64'(sb.size()), 64'(0));
    sk_ready = 1'b1;
  endtask

  task automatic wait_round(input logic [3:0] r);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = sk_valid && (sk_round == r);
    end
    if (!hit) check("reach_round", 64'(sk_round), 64'(r));
  endtask

  initial begin
    rst_n = 1'b1; key_valid = 1'b0; key_in = '0; decrypt = 1'b0; abort = 1'b0; sk_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_sk_valid", 64'(sk_valid), 64'(0));
    check("rst_subkey", 64'(subkey), 64'(0));
    check("rst_sk_round", 64'(sk_round), 64'(0));
    check("rst_sk_last", 64'(sk_last), 64'(0));
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("rst_key_ready", 64'(key_ready), 64'(1));

    // Encrypt, full-rate consumer.
    send_key(KEY_A, 1'b0);
    wait_done(1'b0);
    check("enc_k1", 64'(obs[0]), 64'(48'h1B02EFFC7072));
    check("enc_k2", 64'(obs[1]), 64'(48'h79AED9DBC9E5));
    check("enc_k16", 64'(obs[15]), 64'(48'hCB3D8B0E17F5));
    check("enc_beats", 64'(hs_cnt), 64'(16));
    check("enc_span", 64'(hs_last - hs_first), 64'(15));

    // Decrypt order.
    send_key(KEY_A, 1'b1);
    wait_done(1'b0);
    check("dec_beat0", 64'(obs[0]), 64'(48'hCB3D8B0E17F5));
    check("dec_beat15", 64'(obs[15]), 64'(48'h1B02EFFC7072));

    // Random backpressure.
    send_key(KEY_A, 1'b0);
    wait_done(1'b1);
    check("bp_beats", 64'(hs_cnt), 64'(16));

    // Key offered while busy must be ignored.
    send_key(KEY_A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    key_valid = 1'b1; key_in = KEY_C; decrypt = 1'b1;
    @(negedge clk);
    check("busy_key_ready", 64'(key_ready), 64'(0));
    @(posedge clk);
    #1 key_valid = 1'b0;
    wait_done(1'b0);
    check("busy_beats", 64'(hs_cnt), 64'(16));

    // Abort together with the beat-5 handshake.
    send_key(KEY_B, 1'b0);
    wait_round(4'd5);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_sk_valid", 64'(sk_valid), 64'(0));
    check("abort_key_ready", 64'(key_ready), 64'(1));
    check("abort_sk_round", 64'(sk_round), 64'(0));
    check("abort_sk_last", 64'(sk_last), 64'(0));
    check("abort_beats", 64'(hs_cnt), 64'(6));
    send_key(KEY_B, 1'b1);
    wait_done(1'b0);

    // Asynchronous reset mid-schedule.
    send_key(KEY_C, 1'b0);
    wait_round(4'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sk_valid", 64'(sk_valid), 64'(0));
    check("arst_subkey", 64'(subkey), 64'(0));
    check("arst_sk_round", 64'(sk_round), 64'(0));
    check("arst_sk_last", 64'(sk_last), 64'(0));
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("arst_key_ready", 64'(key_ready), 64'(1));
    send_key(KEY_C, 1'b0);
    wait_done(1'b0);
    check("arst_restart_beats", 64'(hs_cnt), 64'(16));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
